// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Optional parity support is enabled by defining PARITY_EN.
package serial_frame_pkg;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  // Total line bits per frame: start + data + [parity] + stop.
  function automatic int unsigned frame_len(input int unsigned n);
`ifdef PARITY_EN
    return n + 3;
`else
    return n + 2;
`endif
  endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// Output word stream of the frame receiver: valid/ready handshake with data.
interface serial_frame_deser_if #(parameter int N = 8);
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_frame_fifo.sv
// Small synchronous FIFO; a pop in the same cycle frees a full slot for a push.
module serial_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_frame_deser.sv
// Serial-to-parallel frame receiver (start 1, N data bits LSB first, stop 0).
// Define PARITY_EN to add an even-parity bit between data and stop.
module serial_frame_deser
  import serial_frame_pkg::*;
#(
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_in,
  serial_frame_deser_if.master        stream,
  output logic                        frame_err,
  output logic                        par_err,
  output logic                        overrun
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  word;
  logic [N-1:0]  head;
  logic          par_ok;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

`ifdef PARITY_EN
  logic par_bit;
  assign par_ok = ~(^word ^ par_bit);
`else
  assign par_ok  = 1'b1;
  assign par_err = 1'b0;
`endif

  assign pop              = ~empty & stream.out_ready;
  assign push             = (state == STOP) && (s_in == STOP_BIT) && par_ok;
  assign stream.out_valid = ~empty;
  assign stream.out_data  = head;

  serial_frame_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_EN
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_EN
      par_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s_in == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          word[cnt] <= s_in;
          if (cnt == LAST) begin
`ifdef PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          par_bit <= s_in;
          state   <= STOP;
        end
`endif
        STOP: begin
          // Return to IDLE unconditionally so a bad stop bit never doubles as a start bit.
          state <= IDLE;
          if (s_in != STOP_BIT) begin
            frame_err <= 1'b1;
          end else if (!par_ok) begin
`ifdef PARITY_EN
            par_err <= 1'b1;
`endif
          end else if (full && !pop) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_frame_deser.md
# serial_frame_deser

Serial-to-parallel frame receiver placed directly downstream of the free-running serial shift register. Consumes one bit per clock from the shift-register output, hunts for a start bit and assembles an N-bit word (LSB first). Checks framing and pushes good words into a small output FIFO drained by a valid/ready handshake. Malformed frames and overruns are flagged with one-cycle pulses.

## Interface
- N, 8: data bits per frame (≥2)
- FIFO_DEPTH, 2: output FIFO entries (power of 2, ≥2)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- s_in  input  1  serial line, one bit per cycle, idles 0
- out_data  output  N  head-of-FIFO word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- frame_err  output  1  one-cycle pulse: bad stop bit
- par_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN only, else tied 0)
- overrun  output  1  one-cycle pulse: good frame dropped, FIFO full

## Operation
- Frame: start bit 1, N data bits LSB first, [parity bit], stop bit 0.
- FSM states: IDLE, DATA, PARITY (PARITY_EN only), STOP.
- IDLE: s_in=1 → DATA, bit counter cleared; s_in=0 → stay.
- DATA: shift s_in into word register at bit position = counter; after N bits → PARITY if PARITY_EN, else STOP.
- PARITY: latch s_in as received parity → STOP.
- STOP: always → IDLE.
  - s_in=1 → frame_err, word discarded.
  - parity mismatch → par_err, word discarded.
  - Both errors at once: frame_err only.
  - Otherwise push word; FIFO full → overrun, word dropped, FIFO unchanged.
- A stop-bit value of 1 is never reinterpreted as a start bit.
- Back-to-back frames with zero idle gap supported: a start bit may arrive in the cycle immediately after STOP.
- FIFO push and pop in the same cycle are both legal:
  - when full, the pop frees the slot, so the push succeeds with no overrun;
  - when empty, there is no bypass, so the new word is visible next cycle.
- out_data is held stable while out_valid && !out_ready.
- Reset (any time, including mid-frame):
  - FSM → IDLE, counter 0, FIFO emptied, partial word lost.
  - out_valid=0, out_data=0, frame_err=0, par_err=0, overrun=0.

## Timing
- Edge sampling start bit = cycle 0.
- Data bit k sampled at cycle k+1.
- Parity at N+1; stop at N+1 (no parity) or N+2 (parity).
- Push occurs at the stop-sampling edge.
- out_valid rises after that edge, so it is visible in the cycle following stop sampling when the FIFO was empty.
- Error and overrun pulses are registered and high for exactly the cycle following the stop-sampling edge.
- Throughput: one word per N+2 (or N+3) cycles.
- Pop: FIFO advances on the edge where out_valid && out_ready.

## Configuration
- PARITY_EN defined:
  - PARITY state present; frame is N+3 bits.
  - Even parity: XOR of data bits and parity bit must be 0.
  - par_err is live.
- PARITY_EN undefined:
  - No PARITY state; frame is N+2 bits.
  - par_err constant 0.

## Structure
- Shared package serial_frame_pkg:
  - FSM state enum;
  - START_BIT=1, STOP_BIT=0, IDLE_LEVEL=0 constants;
  - function returning frame length for given N and PARITY_EN.
- One sub-module: serial_frame_fifo, a synchronous FIFO with parameters width N and FIFO_DEPTH.
  - Ports: push/pop/full/empty/dout; reset to empty.
- FSM, counter and word register live in the top.

## Test plan
- N=8, no parity:
  - send 1,1,0,1,0,0,1,0,1,0 (0xA5), out_ready=1 → out_valid high for one cycle, out_data=0xA5, frame 10 cycles, no error pulses.
  - stop bit driven 1 on frame 0x3C → frame_err one cycle, out_valid stays 0, next frame 0x81 received correctly.
- Back-to-back frames 0x01, 0xFF, 0x55 with zero gap, out_ready=0 → FIFO (depth 2) holds 0x01, 0xFF; overrun pulses on 0x55. Raise out_ready → pops 0x01 then 0xFF, then out_valid=0.
- FIFO full, out_ready=1 in the cycle a good frame 0x77 completes → no overrun, 0x77 delivered after the two stored words.
- Assert rst after 4 data bits of a frame, release, send 0x12 → only 0x12 delivered, all outputs 0 during reset.
- PARITY_EN, frame 0xA5:
  - parity bit 0 → accepted;
  - parity bit 1 → par_err one cycle, nothing pushed;
  - parity bit 1 and stop bit 1 → frame_err only.
